// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scanner.
package seg_pkg;

  // Scan FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GAP  = 2'd1;
  localparam state_t ST_SHOW = 2'd2;

  // Outputs are active-low, so all-ones means nothing lit / nothing selected.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_NONE  = 8'hFF;

  // Segment pattern with every segment off (used for leading-zero blanking).
  localparam logic [6:0] SEG7_OFF = 7'h7F;

  // Active-low g..a patterns for hex digits 0..F.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port of the segment scanner.
// Handshake: a write happens on every rising clk edge where wr_en=1; there is
// no ready, the scanner accepts one write per cycle unconditionally.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/hex7_dec.sv
// Combinational hex to active-low 7-segment decoder (g..a).
module hex7_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg7
);
  assign seg7 = HEX7_TABLE[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with digit storage,
// blanking gap at the start of each slot and optional leading-zero blanking.
// seg/sel are registered from the next-state values so they change on the
// same edge as the FSM, and stored digits reach the pins one clock after a write.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzb,
  seg_scan_ctrl_if.slave        wr,
  output logic [7:0]            seg,
  output logic [7:0]            sel,
  output logic                  frame_done,
  output state_t                dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          frame_end;
  logic [3:0]    code [8];
  logic [7:0]    dp_q;
  logic [7:0]    zero_from;
  logic          blank;
  logic [6:0]    dec_seg;

  assign dbg_state = state;

  hex7_dec u_dec (
    .hex  (code[idx_nxt]),
    .seg7 (dec_seg)
  );

  // Next-state logic: en low forces IDLE from anywhere; otherwise GAP then SHOW per slot.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        ST_GAP: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == GAP_LAST) state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = ST_GAP;
            cnt_nxt   = '0;
            idx_nxt   = idx + 3'd1;
            frame_end = (idx == 3'd7);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // zero_from[i] is set when digit i and every digit above it hold code 0.
  always_comb begin
    zero_from = '1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (j >= i && code[j] != 4'd0) zero_from[i] = 1'b0;
      end
    end
  end

  assign blank = lzb && (idx_nxt != 3'd0) && zero_from[idx_nxt];

  // Scan FSM, slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Digit storage; writes are independent of scanning so none are ever dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) code[i] <= 4'd0;
      dp_q <= '0;
    end else if (wr.wr_en) begin
      code[wr.wr_addr] <= wr.wr_data;
      dp_q[wr.wr_addr] <= wr.wr_dp;
    end
  end

  // Registered pin drivers, computed from the state being entered on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      sel        <= SEL_NONE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state_nxt == ST_SHOW) begin
        sel <= ~(8'd1 << idx_nxt);
        seg <= {~dp_q[idx_nxt], blank ? SEG7_OFF : dec_seg};
      end else begin
        sel <= SEL_NONE;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a timeline reference model predicts
// {seg, sel, frame_done} after every rising edge, a monitor compares on the
// falling edge.
module tb_seg_scan_ctrl;
  localparam int SCAN_DIV = 8;
  localparam int GAP_CYC  = 2;
  localparam int FRAME    = 8 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       lzb;
  logic [7:0] seg;
  logic [7:0] sel;
  logic       frame_done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seg_scan_ctrl_if wbus ();

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lzb        (lzb),
    .wr         (wbus),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Display as a timeline: after the k-th enabled edge, position p=k-1 picks
  // slot p/SCAN_DIV (mod 8) and offset p%SCAN_DIV; offsets below GAP_CYC are dark.
  logic [7:0] hex_ref [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic [3:0] m_code [8];
  logic       m_dp   [8];
  bit         m_active;
  int         m_k;

  task automatic model_clear();
    m_active = 0;
    m_k      = 0;
    for (int i = 0; i < 8; i++) begin
      m_code[i] = 4'd0;
      m_dp[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [7:0] e_seg, e_sel, pat;
    logic       e_fd;
    int         p, slot, offs;
    bit         dark_lead;
    e_seg = 8'hFF;
    e_sel = 8'hFF;
    e_fd  = 1'b0;
    if (!rst_n) begin
      model_clear();
      exp_q.push_back({e_seg, e_sel, e_fd});
      return;
    end
    if (!en) begin
      m_active = 0;
      m_k      = 0;
    end else begin
      m_k      = m_active ? m_k + 1 : 1;
      m_active = 1;
      p    = m_k - 1;
      slot = (p / SCAN_DIV) % 8;
      offs = p % SCAN_DIV;
      e_fd = (p > 0) && (p % FRAME == 0);
      if (offs >= GAP_CYC) begin
        e_sel = ~(8'd1 << slot);
        dark_lead = lzb && (slot != 0);
        for (int j = slot; j < 8; j++) if (m_code[j] != 4'd0) dark_lead = 0;
        pat   = hex_ref[m_code[slot]];
        e_seg = {~m_dp[slot], dark_lead ? 7'h7F : pat[6:0]};
      end
    end
    exp_q.push_back({e_seg, e_sel, e_fd});
    if (wbus.wr_en) begin
      m_code[wbus.wr_addr] = wbus.wr_data;
      m_dp[wbus.wr_addr]   = wbus.wr_dp;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Asynchronous reset discards any prediction made for the interrupted cycle.
  initial forever begin
    @(negedge rst_n);
    exp_q.delete();
    model_clear();
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("seg", 32'(seg), 32'(e[16:9]));
        check("sel", 32'(sel), 32'(e[8:1]));
        check("frame_done", 32'(frame_done), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic write_digit(input logic [2:0] a, input logic [3:0] d, input logic p);
    wbus.wr_en   = 1'b1;
    wbus.wr_addr = a;
    wbus.wr_data = d;
    wbus.wr_dp   = p;
    @(negedge clk);
    wbus.wr_en   = 1'b0;
  endtask

  task automatic wait_sel(input logic [7:0] v, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel == v) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_fd(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (frame_done) c++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd_cnt;
    rst_n        = 1'b0;
    en           = 1'b0;
    lzb          = 1'b0;
    wbus.wr_en   = 1'b0;
    wbus.wr_addr = 3'd0;
    wbus.wr_data = 4'd0;
    wbus.wr_dp   = 1'b0;

    // Reset held with clock running.
    run(4);
    check("rst_seg", 32'(seg), 32'h0FF);
    check("rst_sel", 32'(sel), 32'h0FF);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Release with en=1: first digit select three clocks later.
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("pre_show_sel", 32'(sel), 32'h0FF);
    @(posedge clk);
    #1 check("first_show_sel", 32'(sel), 32'h0FE);
    @(negedge clk);

    // Full scan with digits 0..7.
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i), 1'b0);
    count_fd(2 * FRAME, fd_cnt);
    check("frame_done_per_2_frames", 32'(fd_cnt), 32'd2);

    // Hex b with dp, then d rewritten while digit 0 is on.
    write_digit(3'd0, 4'hB, 1'b1);
    wait_sel(8'hFF, "wait_gap_hex");
    wait_sel(8'hFE, "wait_digit0_hex");
    check("hex_b_dp_seg", 32'(seg), 32'h003);
    write_digit(3'd0, 4'hD, 1'b0);
    @(negedge clk);
    check("hex_d_seg", 32'(seg), 32'h0A1);

    // Back-to-back writes to one address resolve last-wins.
    write_digit(3'd3, 4'h9, 1'b0);
    write_digit(3'd3, 4'hA, 1'b1);
    run(FRAME + 8);

    // Leading-zero blanking.
    for (int i = 1; i < 8; i++) write_digit(3'(i), 4'd0, 1'b0);
    write_digit(3'd0, 4'd5, 1'b0);
    lzb = 1'b1;
    run(FRAME + 8);
    lzb = 1'b0;
    run(FRAME + 8);

    // Enable dropped mid-SHOW.
    wait_sel(8'hFF, "wait_gap_en");
    wait_sel(8'hFE, "wait_digit0_en");
    en = 1'b0;
    @(negedge clk);
    check("en_drop_sel", 32'(sel), 32'h0FF);
    check("en_drop_seg", 32'(seg), 32'h0FF);
    count_fd(FRAME + 8, fd_cnt);
    check("en_low_no_frame_done", 32'(fd_cnt), 32'd0);
    en = 1'b1;
    run(20);

    // Asynchronous reset mid-SHOW, observed before any further clock edge.
    wait_sel(8'hFF, "wait_gap_rst");
    wait_sel(8'hFE, "wait_digit0_rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'h0FF);
    check("async_rst_sel", 32'(sel), 32'h0FF);
    check("async_rst_frame_done", 32'(frame_done), 32'h0);
    run(3);
    rst_n = 1'b1;
    run(FRAME);

    // Write collision: rewrite digit 2 on the edge that ends its slot.
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(8 + i), 1'(i % 2));
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    run(3 * SCAN_DIV);
    write_digit(3'd2, 4'hE, 1'b1);
    run(2 * FRAME);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      wbus.wr_en   = ($urandom_range(0, 3) == 0);
      wbus.wr_addr = 3'($urandom_range(0, 7));
      wbus.wr_data = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      wbus.wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) lzb = ~lzb;
      en = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    wbus.wr_en = 1'b0;
    en = 1'b0;
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clocks per digit slot (1 kHz slot rate at 50 MHz); legal range 4..2^20.
REQ-002 Parameter GAP_CYC, default 16: blanking clocks at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 Port clk, input, 1: system clock; all state is updated on the rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-005 Port en, input, 1: scan enable.
REQ-006 Port wr_en, input, 1: single-cycle write strobe for one digit.
REQ-007 Port wr_addr, input, 3: digit index to write; 0 is the rightmost digit.
REQ-008 Port wr_data, input, 4: hex code to store in the addressed digit.
REQ-009 Port wr_dp, input, 1: decimal-point enable to store in the addressed digit.
REQ-010 Port lzb, input, 1: leading-zero blanking enable.
REQ-011 Port seg, output, 8: segment drive, active-low; bit7 = dp, bits6..0 = g..a.
REQ-012 Port sel, output, 8: digit select, active-low, at most one bit low at a time.
REQ-013 Port frame_done, output, 1: one-clock pulse after digit 7's slot ends.

Function
REQ-014 Storage: 8 x {4-bit code, 1-bit dp} registers; a write on edge N is visible in the registers after edge N.
REQ-015 FSM states: IDLE, GAP, SHOW.
REQ-016 FSM transitions:
- IDLE->GAP when en=1; digit index starts at 0.
- GAP->SHOW after GAP_CYC clocks.
- SHOW->GAP when the slot counter reaches SCAN_DIV-1; the digit index advances and wraps 7->0.
REQ-017 When en=0 in any state, the FSM SHALL enter IDLE on the next edge and clear the slot counter and digit index; re-enable restarts at digit 0 with GAP.
REQ-018 The slot counter SHALL count 0..SCAN_DIV-1, with GAP covering counts 0..GAP_CYC-1 and SHOW covering the remainder.
REQ-019 Outputs in IDLE and GAP: sel=8'hFF and seg=8'hFF.
REQ-020 Outputs in SHOW: sel = ~(1<<idx); seg[6:0] = decode(code[idx]); seg[7] = ~dp[idx].
REQ-021 seg and sel SHALL be registered; register contents SHALL appear on the outputs one clock after they change, including writes to the digit currently shown.
REQ-022 Decode table, hex, dp bit set (active-low, off):
- 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
- 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
REQ-023 Leading-zero blanking: when lzb=1, digit i (i>=1) SHALL show seg[6:0]=7'h7F if it and every digit above it hold 0; dp is still honoured and digit 0 is never blanked.
REQ-024 frame_done SHALL pulse high for exactly one clock on the SHOW->GAP transition out of digit 7; it never pulses while en=0.
REQ-025 A write issued in the same cycle as a slot transition SHALL take effect, with no write lost; back-to-back writes to the same address SHALL be resolved last-wins.

Reset
REQ-026 While rst_n=0:
- state=IDLE; slot counter, digit index, all codes and all dp bits = 0.
- seg=8'hFF, sel=8'hFF, frame_done=0.
REQ-027 Reset asserted mid-slot SHALL force the REQ-026 values immediately, without waiting for clk; after release, scanning restarts at digit 0.

Structure
REQ-028 Shared package seg_pkg SHALL hold:
- the FSM state type;
- constants SEG_BLANK=8'hFF and SEL_NONE=8'hFF;
- the 16-entry decode table.
REQ-029 The combinational 7-segment decoder SHALL be the single sub-module hex7_dec (4-bit in, 7-bit active-low out); the scan counter and FSM stay in seg_scan_ctrl.

Verification
REQ-030 The bench SHALL use SCAN_DIV=8, GAP_CYC=2 and cover:
- Reset: hold rst_n=0, toggle clk -> seg=FF, sel=FF, frame_done=0; release with en=1 -> first sel=FE appears 3 clocks later.
- Full scan: write digits 0..7 = 0,1,2,3,4,5,6,7 -> sel walks FE,FD,...,7F with seg C0,F9,A4,B0,99,92,82,F8; frame_done pulses once per 64 clocks.
- Hex and dp: write digit 0 = b with dp=1 -> seg=03 in digit 0's SHOW; write d -> A1 after 1 clock.
- Blanking: write digits {0:5, others 0}, lzb=1 -> digits 1..7 seg=FF, digit 0 seg=92; lzb=0 -> digits 1..7 seg=C0.
- Enable drop and async reset: deassert en mid-SHOW -> sel=FF next clock, no frame_done; assert rst_n mid-slot -> outputs FF without a clock edge.
- Write collision: wr_en to the displayed digit on the slot's final clock -> the new value appears at the next visit, with no corruption of other digits.
